// File: rtl/eddsa_msg_feeder.sv
// Packs a 64-bit host word stream into 1024-bit blocks for the EdDSA25519 core.
// It marks the final block and reports the total message length in bits.
module eddsa_msg_feeder #(
   parameter int WIDTH      = 64,
   parameter int SIZE_BLOCK = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [WIDTH-1:0]      s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   input  logic [3:0]            s_nbytes,
   output logic                  s_ready,
   input  logic                  block_ready,
   output logic [1:0]            block_valid,
   output logic [SIZE_BLOCK-1:0] message,
   output logic [WIDTH-1:0]      len_message,
   output logic                  busy
);
   localparam int NUM_WORDS = SIZE_BLOCK / WIDTH;
   localparam int CNT_W     = $clog2(NUM_WORDS);
   localparam int IDX_W     = $clog2(SIZE_BLOCK);
   localparam int BYTES     = WIDTH / 8;

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   localparam logic [1:0] BV_NONE  = 2'b00;
   localparam logic [1:0] BV_MID   = 2'b01;
   localparam logic [1:0] BV_FINAL = 2'b11;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

   logic [0:0]            state_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [SIZE_BLOCK-1:0] message_r;
   logic [1:0]            block_valid_r;
   logic [WIDTH-1:0]      len_r;
   logic                  busy_r;
   logic                  s_ready_r;

   logic                  word_xfer_s;
   logic [3:0]            nb_s;
   logic [WIDTH-1:0]      word_s;
   logic [WIDTH-1:0]      len_add_s;
   logic [IDX_W-1:0]      base_s;

   // Keeps bytes 0..nb-1 (byte 0 is the most significant) and zeroes the rest.
   function automatic logic [WIDTH-1:0] keep_bytes(input logic [WIDTH-1:0] data,
                                                   input logic [3:0]       nb);
      logic [WIDTH-1:0] res;
      res = {WIDTH{1'b0}};
      for (int i = 0; i < BYTES; i++) begin
         if (i < int'(nb)) begin
            res[WIDTH-1-8*i -: 8] = data[WIDTH-1-8*i -: 8];
         end else begin
            res[WIDTH-1-8*i -: 8] = 8'h00;
         end
      end
      return res;
   endfunction

   // Word-path decode: tail masking, length increment and target slot.
   always_comb begin
      word_xfer_s = s_valid & s_ready_r;
      if (s_nbytes > 4'(BYTES)) begin
         nb_s = 4'(BYTES);
      end else begin
         nb_s = s_nbytes;
      end
      if (s_last) begin
         word_s    = keep_bytes(s_data, nb_s);
         len_add_s = WIDTH'({nb_s, 3'b000});
      end else begin
         word_s    = s_data;
         len_add_s = WIDTH'(WIDTH);
      end
      base_s = IDX_W'((NUM_WORDS - 1 - int'(cnt_r)) * WIDTH);
   end

   // Fill/send state machine; clr acts as a synchronous copy of the reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_FILL;
         cnt_r         <= {CNT_W{1'b0}};
         message_r     <= {SIZE_BLOCK{1'b0}};
         block_valid_r <= BV_NONE;
         len_r         <= {WIDTH{1'b0}};
         busy_r        <= 1'b0;
         s_ready_r     <= 1'b1;
      end else if (clr) begin
         state_r       <= ST_FILL;
         cnt_r         <= {CNT_W{1'b0}};
         message_r     <= {SIZE_BLOCK{1'b0}};
         block_valid_r <= BV_NONE;
         len_r         <= {WIDTH{1'b0}};
         busy_r        <= 1'b0;
         s_ready_r     <= 1'b1;
      end else begin
         case (state_r)
            ST_FILL: begin
               if (word_xfer_s) begin
                  message_r[base_s +: WIDTH] <= word_s;
                  cnt_r  <= cnt_r + CNT_W'(1);
                  busy_r <= 1'b1;
                  // A new message restarts the length; later words accumulate.
                  len_r  <= busy_r ? (len_r + len_add_s) : len_add_s;
                  if (s_last) begin
                     state_r       <= ST_SEND;
                     block_valid_r <= BV_FINAL;
                     s_ready_r     <= 1'b0;
                  end else if (cnt_r == CNT_LAST) begin
                     state_r       <= ST_SEND;
                     block_valid_r <= BV_MID;
                     s_ready_r     <= 1'b0;
                  end
               end
            end
            ST_SEND: begin
               if (block_ready) begin
                  state_r       <= ST_FILL;
                  cnt_r         <= {CNT_W{1'b0}};
                  message_r     <= {SIZE_BLOCK{1'b0}};
                  block_valid_r <= BV_NONE;
                  s_ready_r     <= 1'b1;
                  if (block_valid_r == BV_FINAL) begin
                     busy_r <= 1'b0;
                  end
               end
            end
            default: begin
               state_r       <= ST_FILL;
               cnt_r         <= {CNT_W{1'b0}};
               message_r     <= {SIZE_BLOCK{1'b0}};
               block_valid_r <= BV_NONE;
               s_ready_r     <= 1'b1;
            end
         endcase
      end
   end

   assign s_ready     = s_ready_r;
   assign block_valid = block_valid_r;
   assign message     = message_r;
   assign len_message = len_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_eddsa_msg_feeder.sv
// Directed bench for eddsa_msg_feeder: packing, final-block marking, length,
// handshake stability, async reset and synchronous clear.
module tb_eddsa_msg_feeder;
   logic          clk;
   logic          rst;
   logic          clr;
   logic [63:0]   s_data;
   logic          s_valid;
   logic          s_last;
   logic [3:0]    s_nbytes;
   logic          s_ready;
   logic          block_ready;
   logic [1:0]    block_valid;
   logic [1023:0] message;
   logic [63:0]   len_message;
   logic          busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] exp_slot [16];
   logic [63:0] exp_len;

   eddsa_msg_feeder dut (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_nbytes    (s_nbytes),
      .s_ready     (s_ready),
      .block_ready (block_ready),
      .block_valid (block_valid),
      .message     (message),
      .len_message (len_message),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [63:0] wd(input int t, input int k);
      return {16'hCAFE, 8'(t), 8'(k), 32'h1357_9BDF ^ (32'(k) * 32'd7)};
   endfunction

   function automatic logic [63:0] slot_of(input int k);
      return message[1023 - 64*k -: 64];
   endfunction

   task automatic clear_exp();
      for (int k = 0; k < 16; k++) exp_slot[k] = 64'd0;
   endtask

   task automatic send_word(input logic [63:0] data, input logic last, input logic [3:0] nb);
      int t = 0;
      while (s_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t == 20) check("sready_timeout", 64'(s_ready), 64'd1);
      s_data   = data;
      s_valid  = 1'b1;
      s_last   = last;
      s_nbytes = nb;
      @(negedge clk);
      s_valid  = 1'b0;
      s_last   = 1'b0;
      s_nbytes = 4'd0;
      s_data   = 64'd0;
   endtask

   task automatic check_outputs_reset(input string tag);
      check({tag, "_bv"},    64'(block_valid), 64'd0);
      check({tag, "_busy"},  64'(busy), 64'd0);
      check({tag, "_len"},   len_message, 64'd0);
      check({tag, "_ready"}, 64'(s_ready), 64'd1);
      check({tag, "_msg0"},  64'(message != 1024'd0), 64'd0);
   endtask

   task automatic check_block(input string tag, input logic [1:0] exp_bv, input int hold);
      int t = 0;
      logic [1023:0] snap_msg;
      logic [63:0]   snap_len;
      logic [1:0]    snap_bv;
      while (block_valid === 2'b00 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_bv"}, 64'(block_valid), 64'(exp_bv));
      if (exp_bv == 2'b11) check({tag, "_len"}, len_message, exp_len);
      for (int k = 0; k < 16; k++) check($sformatf("%s_slot%0d", tag, k), slot_of(k), exp_slot[k]);
      check({tag, "_sready"}, 64'(s_ready), 64'd0);
      snap_msg = message;
      snap_len = len_message;
      snap_bv  = block_valid;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         check({tag, "_hold_bv"},  64'(block_valid), 64'(snap_bv));
         check({tag, "_hold_len"}, len_message, snap_len);
         check({tag, "_hold_msg"}, 64'(message != snap_msg), 64'd0);
         check({tag, "_hold_rdy"}, 64'(s_ready), 64'd0);
      end
      block_ready = 1'b1;
      @(negedge clk);
      block_ready = 1'b0;
      check({tag, "_after_bv"},  64'(block_valid), 64'd0);
      check({tag, "_after_rdy"}, 64'(s_ready), 64'd1);
      check({tag, "_after_msg"}, 64'(message != 1024'd0), 64'd0);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; s_data = 64'd0; s_valid = 1'b0; s_last = 1'b0;
      s_nbytes = 4'd0; block_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs_reset("reset");
      rst = 1'b0;
      // block_ready while idle must be ignored
      block_ready = 1'b1;
      @(negedge clk);
      block_ready = 1'b0;
      check_outputs_reset("idle_ready");

      // 1: three words, partial tail
      clear_exp();
      exp_slot[0] = wd(1, 0);
      exp_slot[1] = wd(1, 1);
      exp_slot[2] = 64'h1122_3344_5500_0000;
      exp_len = 64'd168;
      send_word(wd(1, 0), 1'b0, 4'd0);
      check("t1_busy", 64'(busy), 64'd1);
      send_word(wd(1, 1), 1'b0, 4'd0);
      send_word(64'h1122_3344_5566_7788, 1'b1, 4'd5);
      check("t1_latency", 64'(block_valid), 64'd3);
      check_block("t1", 2'b11, 2);
      check("t1_busy_end", 64'(busy), 64'd0);
      check("t1_len_kept", len_message, 64'd168);

      // 2: exactly 16 words, last on the 16th
      clear_exp();
      for (int k = 0; k < 16; k++) exp_slot[k] = wd(2, k);
      exp_len = 64'd1024;
      for (int k = 0; k < 15; k++) send_word(wd(2, k), 1'b0, 4'd0);
      check("t2_no_early_blk", 64'(block_valid), 64'd0);
      send_word(wd(2, 15), 1'b1, 4'd8);
      check_block("t2", 2'b11, 0);
      repeat (5) @(negedge clk);
      check("t2_no_second_blk", 64'(block_valid), 64'd0);
      check("t2_busy", 64'(busy), 64'd0);

      // 3: 17 words, slow consumer
      clear_exp();
      for (int k = 0; k < 16; k++) exp_slot[k] = wd(3, k);
      for (int k = 0; k < 16; k++) send_word(wd(3, k), 1'b0, 4'd0);
      check_block("t3a", 2'b01, 5);
      check("t3_busy_mid", 64'(busy), 64'd1);
      clear_exp();
      exp_slot[0] = wd(3, 16);
      exp_len = 64'd1088;
      send_word(wd(3, 16), 1'b1, 4'd8);
      check_block("t3b", 2'b11, 5);
      check("t3_busy_end", 64'(busy), 64'd0);

      // 4: empty message
      clear_exp();
      exp_len = 64'd0;
      send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
      check("t4_busy", 64'(busy), 64'd1);
      check_block("t4", 2'b11, 1);
      check("t4_busy_end", 64'(busy), 64'd0);

      // 5: async reset mid-message, then a 2-word message
      for (int k = 0; k < 7; k++) send_word(wd(5, k), 1'b0, 4'd0);
      check("t5_busy_pre", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1 check_outputs_reset("t5_async");
      @(negedge clk);
      rst = 1'b0;
      clear_exp();
      exp_slot[0] = wd(5, 10);
      exp_slot[1] = wd(5, 11);
      exp_len = 64'd128;
      send_word(wd(5, 10), 1'b0, 4'd0);
      send_word(wd(5, 11), 1'b1, 4'd8);
      check_block("t5", 2'b11, 0);

      // 6: clr while in SEND, then the same message again
      send_word(wd(6, 0), 1'b1, 4'd8);
      check("t6_pre_bv", 64'(block_valid), 64'd3);
      clr = 1'b1;
      block_ready = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      block_ready = 1'b0;
      check_outputs_reset("t6_clr");
      clear_exp();
      exp_slot[0] = wd(6, 0);
      exp_len = 64'd64;
      send_word(wd(6, 0), 1'b1, 4'd8);
      check_block("t6", 2'b11, 0);

      // 7: s_nbytes above 8 behaves as 8
      clear_exp();
      exp_slot[0] = wd(7, 0);
      exp_slot[1] = wd(7, 1);
      exp_len = 64'd128;
      send_word(wd(7, 0), 1'b0, 4'd3);
      send_word(wd(7, 1), 1'b1, 4'd12);
      check_block("t7", 2'b11, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
